// File: rtl/switch_pkg.sv
// Types shared by the switch ingress and egress ports: lane masks, the stored
// packet and the round-robin pointer.
package switch_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [3:0] port_mask_t;

    typedef struct packed {
        port_mask_t  source;
        logic [7:0]  data;
    } pkt_t;

    typedef logic [1:0] rr_ptr_t;

    // Ingress switch_port forwarding states, kept here so both port types share them.
    typedef enum logic [1:0] {
        SP_IDLE,
        SP_ROUTE,
        SP_HOLD
    } sp_state_t;

endpackage

// File: rtl/switch_lane_fifo.sv
// Per-lane packet FIFO. A push while full is accepted only together with a pop,
// which the parent guarantees by gating push.
module switch_lane_fifo
    import switch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  pkt_t pkt_in,
    input  logic pop,
    output pkt_t pkt_out,
    output logic full,
    output logic empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    pkt_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign pkt_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_egress_port.sv
// Egress port: keeps the lane packets addressed to PORT_ID, buffers them per lane
// and drains the lane FIFOs round-robin onto one valid/ready output.
module switch_egress_port
    import switch_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORTS-1:0]      in_valid,
    input  logic [4*NUM_PORTS-1:0]    in_source,
    input  logic [4*NUM_PORTS-1:0]    in_target,
    input  logic [8*NUM_PORTS-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_source,
    output logic [7:0]                out_data,
    output logic [7:0]                drop_count,
    output logic                      overflow
);

    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    pkt_t                 pkt_in [NUM_PORTS];
    pkt_t                 head   [NUM_PORTS];
    rr_ptr_t              rr_ptr;
    rr_ptr_t              grant;
    logic                 load;
    logic [2:0]           drop_num;
    logic [8:0]           drop_sum;
    logic                 unused_target;

    // Only the PORT_ID bit of each lane's target matters here.
    assign unused_target = ^in_target;

    function automatic rr_ptr_t rr_pick(input port_mask_t req, input rr_ptr_t ptr);
        rr_ptr_t idx;
        rr_ptr_t pick;
        logic    found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + rr_ptr_t'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign load  = (!out_valid || out_ready) && !(&empty);
    assign grant = rr_pick(~empty, rr_ptr);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        assign hit[i]    = in_valid[i] && in_target[4*i + PORT_ID];
        assign pkt_in[i] = '{source: in_source[4*i +: 4], data: in_data[8*i +: 8]};
        assign pop[i]    = load && (grant == rr_ptr_t'(i));
        // A full lane can still accept when it is being drained this cycle.
        assign push[i]   = hit[i] && (!full[i] || pop[i]);
        assign drop[i]   = hit[i] && full[i] && !pop[i];

        switch_lane_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[i]),
            .pkt_in  (pkt_in[i]),
            .pop     (pop[i]),
            .pkt_out (head[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drop_num = drop_num + 3'(drop[i]);
        end
        drop_sum = {1'b0, drop_count} + 9'(drop_num);
    end

    // Output register, arbiter pointer and drop statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_source <= '0;
            out_data   <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_source <= head[grant].source;
                out_data   <= head[grant].data;
                rr_ptr     <= grant + 1'b1;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
            if (|drop) begin
                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
                overflow   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_egress_port.sv
// Scoreboard bench for switch_egress_port at PORT_ID=2, FIFO_DEPTH=4: expected
// packets are queued as stimulus is driven and popped on each output handshake.
module tb_switch_egress_port;

    localparam int PORT_ID    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid;
    logic [15:0] in_source;
    logic [15:0] in_target;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_source;
    logic [7:0]  out_data;
    logic [7:0]  drop_count;
    logic        overflow;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [11:0] sb [$];
    logic [11:0] exp_pkt;

    switch_egress_port #(
        .PORT_ID    (PORT_ID),
        .NUM_PORTS  (4),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_source  (in_source),
        .in_target  (in_target),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_source (out_source),
        .out_data   (out_data),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_packet: got src=%b data=%h, required no packet", out_source, out_data);
            end else begin
                exp_pkt = sb.pop_front();
                if ({out_source, out_data} !== exp_pkt) begin
                    tests_failed++;
                    $display("[TB] FAIL packet_order: got src=%b data=%h, required src=%b data=%h",
                             out_source, out_data, exp_pkt[11:8], exp_pkt[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        in_source = '0;
        in_target = '0;
        in_data   = '0;
    endtask

    task automatic set_lane(input int lane, input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] data);
        in_valid[lane]          = 1'b1;
        in_source[4*lane +: 4]  = src;
        in_target[4*lane +: 4]  = tgt;
        in_data[8*lane +: 8]    = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
        tests_run++;
        if (out_source !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_out_source: got %b, required 0000", out_source); end
        tests_run++;
        if (out_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h, required 00", out_data); end
        tests_run++;
        if (drop_count !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_drop_count: got %0d, required 0", drop_count); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b, required 0", overflow); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_hit();
        out_ready = 1'b1;
        set_lane(0, 4'b0001, 4'b0100, 8'hA5);
        sb.push_back({4'b0001, 8'hA5});
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_latency_early: got out_valid=%b in cycle 1, required 0", out_valid); end
        tick();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_source !== 4'b0001 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_cycle2: got v=%b src=%b data=%h, required v=1 src=0001 data=a5", out_valid, out_source, out_data);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_cycle3: got out_valid=%b, required 0", out_valid); end
        tick();
    endtask

    task automatic test_target_miss();
        out_ready = 1'b1;
        set_lane(1, 4'b0010, 4'b0010, 8'h77);
        set_lane(3, 4'b1000, 4'b1100, 8'h3C);
        set_lane(0, 4'b0001, 4'b0100, 8'h99);
        in_valid[0] = 1'b0;
        sb.push_back({4'b1000, 8'h3C});
        tick();
        idle_inputs();
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("[TB] FAIL miss_drain: got %0d pending, required 0", sb.size()); end
        tests_run++;
        if (drop_count !== 8'h00) begin tests_failed++; $display("[TB] FAIL miss_drop_count: got %0d, required 0", drop_count); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL miss_idle: got out_valid=%b, required 0", out_valid); end
        tick();
    endtask

    task automatic test_all_lanes();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 4'(1 << i), 4'b0100, 8'h10 + 8'(i));
            sb.push_back({4'(1 << i), 8'h10 + 8'(i)});
        end
        tick();
        idle_inputs();
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k)) begin
                tests_failed++;
                $display("[TB] FAIL all_lanes_beat%0d: got v=%b data=%h, required v=1 data=%h", k, out_valid, out_data, 8'h10 + 8'(k));
            end
            tick();
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL all_lanes_end: got out_valid=%b, required 0", out_valid); end
        tick();
    endtask

    task automatic test_stall();
        logic        ready_pat [4];
        logic [11:0] hold_pat  [4];
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        hold_pat  = '{{4'b0001, 8'h40}, {4'b0100, 8'h50}, {4'b0100, 8'h50}, {4'b0100, 8'h50}};
        out_ready = 1'b0;
        set_lane(0, 4'b0001, 4'b0100, 8'h40);
        set_lane(2, 4'b0100, 4'b0100, 8'h50);
        sb.push_back({4'b0001, 8'h40});
        sb.push_back({4'b0100, 8'h50});
        sb.push_back({4'b0001, 8'h41});
        sb.push_back({4'b0100, 8'h51});
        tick();
        set_lane(0, 4'b0001, 4'b0100, 8'h41);
        set_lane(2, 4'b0100, 4'b0100, 8'h51);
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            out_ready = ready_pat[k];
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || {out_source, out_data} !== hold_pat[k]) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: got v=%b src=%b data=%h, required v=1 src=%b data=%h",
                         k, out_valid, out_source, out_data, hold_pat[k][11:8], hold_pat[k][7:0]);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("[TB] FAIL stall_drain: got %0d pending, required 0", sb.size()); end
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_lane(0, 4'b0001, 4'b0100, 8'h20 + 8'(k));
            if (k < 5) sb.push_back({4'b0001, 8'h20 + 8'(k)});
            tick();
        end
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (drop_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL overflow_drop_count: got %0d, required 1", drop_count); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_flag: got %b, required 1", overflow); end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h20) begin
            tests_failed++;
            $display("[TB] FAIL overflow_head: got v=%b data=%h, required v=1 data=20", out_valid, out_data);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("[TB] FAIL overflow_drain: got %0d pending, required 0", sb.size()); end
        tests_run++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_sticky: got drops=%0d ovf=%b, required drops=1 ovf=1", drop_count, overflow);
        end
        tick();
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_lane(1, 4'b0010, 4'b0100, 8'h60 + 8'(k));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_pre: got out_valid=%b, required 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_valid: got %b, required 0", out_valid); end
        tests_run++;
        if (drop_count !== 8'h00 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_stats: got drops=%0d ovf=%b, required drops=0 ovf=0", drop_count, overflow);
        end
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midreset_stale%0d: got v=%b data=%h, required v=0", c, out_valid, out_data);
            end
        end
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b1;
        test_reset();
        test_single_hit();
        test_target_miss();
        test_all_lanes();
        test_stall();
        test_overflow();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/switch_egress_port.md
Name: switch_egress_port

Overview:
- Downstream stage of the per-ingress switch ports.
- One instance per egress port collects the NUM_PORTS switch-port output lanes and keeps the packets whose target bit matches PORT_ID.
- Buffers those packets in per-lane FIFOs, because upstream has no backpressure and up to NUM_PORTS packets can arrive in one cycle.
- Drains the FIFOs round-robin onto a single valid/ready egress interface.

Parameters:
- PORT_ID, 0, index of this egress port (0..NUM_PORTS-1); selects in_target bit.
- NUM_PORTS, 4, number of ingress lanes; fixed at 4 in this release.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-lane packet strobe, lane i = bit i.
- in_source  input  16  lane i source one-hot at [4i+3:4i].
- in_target  input  16  lane i target one-hot at [4i+3:4i].
- in_data  input  32  lane i payload at [8i+7:8i].
- out_valid  output  1  egress packet valid.
- out_ready  input  1  egress sink accepts.
- out_source  output  4  source one-hot of the egress packet.
- out_data  output  8  payload of the egress packet.
- drop_count  output  8  saturating count of dropped packets.
- overflow  output  1  sticky; set on first drop, cleared only by reset.

Behaviour:
- Reset values: out_valid=0, out_source=0, out_data=0, drop_count=0, overflow=0. All FIFOs empty, rr_ptr=0. Reset asserted mid-operation discards all buffered packets immediately.
- Lane hit:
  - hit[i] = in_valid[i] && in_target[4i+PORT_ID]. Other target bits are ignored.
  - Only {source, data} is stored; target is not stored.
- Lane FIFO i:
  - Count is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - push = hit[i] && (count<FIFO_DEPTH || pop[i]). A push on a full FIFO succeeds when the same lane is popped that cycle; count is unchanged.
  - Otherwise a hit on a full FIFO is a drop: drop_count += 1, saturating at 255, and overflow <= 1.
  - Multiple drops in the same cycle add their number, saturating.
- Output stage:
  - load = (!out_valid || out_ready) && any FIFO non-empty.
  - On load: the granted FIFO pops; out_valid <= 1; out_source/out_data <= head entry.
  - If out_valid && out_ready && no FIFO is non-empty: out_valid <= 0. out_source/out_data hold their last value.
  - While out_valid && !out_ready: out_valid, out_source and out_data are held stable.
- Arbiter:
  - Round-robin over non-empty FIFOs, scanning lanes rr_ptr, rr_ptr+1, ... modulo 4.
  - First non-empty lane g wins; on load, rr_ptr <= g+1 (mod 4). rr_ptr changes only on load.
- Latency: hit at cycle N with an empty FIFO and idle output gives out_valid in cycle N+2. There is no bypass path.
- Throughput: 1 packet/cycle while out_ready=1.
- Ordering: in-order per lane. Across lanes, order follows round-robin, not arrival time.
- Simultaneous hits on all 4 lanes in one cycle are all accepted if space exists.

Decomposition:
- Shared package switch_pkg:
  - NUM_PORTS.
  - port_mask_t (logic [3:0]).
  - pkt_t struct {port_mask_t source; logic [7:0] data}.
  - rr_ptr_t (logic [1:0]).
  - The switch_port state enum also moves here for reuse.
- Sub-module switch_lane_fifo, parameterised by FIFO_DEPTH:
  - Interfaces: push/pkt_in, pop/pkt_out, full, empty.
  - Instantiated 4 times.
- The round-robin pick stays local to this module as a function.

Test Plan:
- PORT_ID=2. Lane 0 sends in_valid=0001, source=0001, target=0100, data=0xA5 at cycle 0, out_ready=1 → out_valid=1 in cycle 2 with source=0001, data=0xA5. out_valid returns to 0 in cycle 3.
- PORT_ID=2. Lane 1 sends target=0010 (miss), and lane 3 sends target=1100, data=0x3C → only the lane 3 packet emerges, source=1000. drop_count stays 0.
- All 4 lanes hit in the same cycle with data 0x10, 0x11, 0x12, 0x13, rr_ptr=0, out_ready=1 → outputs 0x10, 0x11, 0x12, 0x13 on consecutive cycles. rr_ptr ends at 0.
- out_ready=0. Lane 0 hits 6 times with FIFO_DEPTH=4 → 1 packet in the output register, 4 in the FIFO, 1 dropped. drop_count=1, overflow=1. Raising out_ready then drains 5 packets in order.
- out_ready toggles 1,0,0,1 while lanes 0 and 2 each hold 2 packets → out_source/out_data are stable while stalled. Grant order is lane 0, 2, 0, 2.
- Assert rst_n=0 while FIFOs hold 3 packets and out_valid=1 → out_valid=0 and drop_count=0 immediately. No stale packet appears after reset release.
